jump_game_ctrl: RTL and testbench
=================================

Name: jump_game_ctrl

Overview:
- Parametrised game engine for the N x N LED-matrix jump game.
- Holds player position, jump/fall physics, map scroll offset, platform collision, score and a game state machine.
- Advances one game step per `tick` strobe from the slow divider.
- Sits between the keypad decode/buffer chain and the row-scan/colour-mix logic. The map ROM is external, read through two combinational read ports.

Parameters:
- N, 8: matrix dimension (rows = columns); power of 2, at least 4.
- MAP_AW, 6: map ROM address width; the offset wraps mod 2^MAP_AW.
- JUMP_H, 3: rise steps per bounce, 1..15.
- SCROLL_ROW, 4: highest on-screen row the player reaches; beyond it the map scrolls. Range 1..N-1.
- SCORE_W, 8: score width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- tick  in  1  one-clk game-step strobe.
- start  in  1  start/restart request, sampled every clk.
- key_left  in  1  move-left request, sampled on tick.
- key_right  in  1  move-right request, sampled on tick.
- scan_idx  in  log2(N)  current display row; 0 = bottom.
- disp_addr  out  MAP_AW  map_offset + scan_idx, mod 2^MAP_AW.
- disp_data  in  N  map row at disp_addr; bit i = column i.
- probe_addr  out  MAP_AW  map_offset + player_y, mod 2^MAP_AW.
- probe_data  in  N  map row at probe_addr.
- green_row  out  N  equals disp_data (combinational pass-through).
- red_row  out  N  player pixel on row scan_idx.
- state  out  2  0 = IDLE, 1 = PLAY, 2 = OVER.
- score  out  SCORE_W  scroll count.
- map_offset  out  MAP_AW  current scroll offset.
- player_x  out  log2(N)  player column.
- player_y  out  log2(N)  player row.

Behaviour:
- Interface: single clock `clk`; reset `rst` is synchronous and active-high. All state registers update on the clk rising edge.
- Reset values: state = IDLE, player_x = N/2, player_y = 0, rise_cnt = JUMP_H, map_offset = 0, score = 0.
- Registered outputs: state, score, map_offset, player_x, player_y.
- Combinational outputs (zero latency): red_row, green_row, disp_addr, probe_addr.
- red_row:
  - IDLE: 0.
  - PLAY and OVER: one-hot(player_x) when scan_idx == player_y, else 0.
- IDLE or OVER with start = 1: next clk enters PLAY and re-initialises all registers to their reset values. A tick in the same cycle is ignored.
- IDLE and OVER ignore tick.
- PLAY ignores start.
- PLAY, on tick; all decisions use pre-tick player_x, player_y and probe_data:
  - Horizontal:
    - left only: x - 1, wrapping 0 -> N-1.
    - right only: x + 1, wrapping N-1 -> 0.
    - both or neither: hold.
  - Rising (rise_cnt > 0): rise_cnt decrements.
    - If player_y < SCROLL_ROW: player_y + 1.
    - Else: player_y holds, map_offset + 1 (wrapping), score + 1 (saturating at 2^SCORE_W - 1).
  - Falling (rise_cnt == 0):
    - probe_data[player_x] == 1: bounce. rise_cnt = JUMP_H, player_y holds.
    - Else if player_y == 0: state = OVER; all position registers hold.
    - Else: player_y - 1.
  - Horizontal and vertical updates apply in the same tick.
- OVER holds every register until start.
- rst asserted mid-PLAY: returns to IDLE on that edge, overriding tick and start.

Optional Feature:
- Macro: JUMP_GAME_BLINK_EN.
- Defined:
  - A 2-bit blink counter clears on entry to OVER and increments on each tick while in OVER.
  - red_row is forced to 0 while counter[1] == 1 (player blinks with a 4-tick period).
  - In OVER, the displayed player row is all-ones instead of one-hot.
- Undefined: OVER shows the static one-hot player pixel; no counter is built.

Test Plan:
1. Reset, then scan rows 0..7 -> state = 0, score = 0, map_offset = 0, red_row = 0 on every row, disp_addr = scan_idx.
2. Defaults; map row0 = 8'hFF, others 0; start, then 7 ticks -> player_y = 1,2,3,2,1,0,0. Tick 7 bounces; tick 8 gives player_y = 1. state = 1 throughout.
3. PLAY at player_x = 0, key_left on tick -> player_x = 7. key_left + key_right together -> player_x unchanged.
4. JUMP_H = 6, SCROLL_ROW = 4, row0 = 8'hFF -> ticks 1-4 give player_y = 1..4. Ticks 5-6 give map_offset = 1,2, score = 2, player_y = 4, probe_addr = 6.
5. All map rows 0; start, 7 ticks -> state = 2 after tick 7 with player_y = 0. Then start -> state = 1, score = 0, map_offset = 0, player_x = 4.
6. start during PLAY -> no change. rst pulsed mid-rise -> state = 0, player_y = 0 next edge. With JUMP_GAME_BLINK_EN in OVER -> red_row on player row = 8'hFF for ticks 0-1, 0 for ticks 2-3.

Source files
------------

// File: rtl/jump_game_ctrl.sv
// Jump-game engine: player physics, map scroll, platform collision, score and game FSM.
// Optional build macro JUMP_GAME_BLINK_EN adds a blinking, full-row player marker in OVER.
module jump_game_ctrl #(
    parameter int unsigned N          = 8,
    parameter int unsigned MAP_AW     = 6,
    parameter int unsigned JUMP_H     = 3,
    parameter int unsigned SCROLL_ROW = 4,
    parameter int unsigned SCORE_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   start,
    input  logic                   key_left,
    input  logic                   key_right,
    input  logic [$clog2(N)-1:0]   scan_idx,
    output logic [MAP_AW-1:0]      disp_addr,
    input  logic [N-1:0]           disp_data,
    output logic [MAP_AW-1:0]      probe_addr,
    input  logic [N-1:0]           probe_data,
    output logic [N-1:0]           green_row,
    output logic [N-1:0]           red_row,
    output logic [1:0]             state,
    output logic [SCORE_W-1:0]     score,
    output logic [MAP_AW-1:0]      map_offset,
    output logic [$clog2(N)-1:0]   player_x,
    output logic [$clog2(N)-1:0]   player_y
);

    localparam int unsigned XW = $clog2(N);
    localparam int unsigned RW = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_OVER = 2'd2;

    localparam logic [XW-1:0] X_INIT    = XW'(N / 2);
    localparam logic [XW-1:0] SCROLL_Y  = XW'(SCROLL_ROW);
    localparam logic [RW-1:0] RISE_INIT = RW'(JUMP_H);

    logic [1:0]         r_state, w_state_nxt;
    logic [XW-1:0]      r_px, w_px_nxt;
    logic [XW-1:0]      r_py, w_py_nxt;
    logic [RW-1:0]      r_rise, w_rise_nxt;
    logic [MAP_AW-1:0]  r_off, w_off_nxt;
    logic [SCORE_W-1:0] r_score, w_score_nxt;
    logic [N-1:0]       w_onehot;
`ifdef JUMP_GAME_BLINK_EN
    logic [1:0]         r_blink, w_blink_nxt;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_px    <= X_INIT;
            r_py    <= '0;
            r_rise  <= RISE_INIT;
            r_off   <= '0;
            r_score <= '0;
`ifdef JUMP_GAME_BLINK_EN
            r_blink <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_px    <= w_px_nxt;
            r_py    <= w_py_nxt;
            r_rise  <= w_rise_nxt;
            r_off   <= w_off_nxt;
            r_score <= w_score_nxt;
`ifdef JUMP_GAME_BLINK_EN
            r_blink <= w_blink_nxt;
`endif
        end
    end

    // Next-state and game-step logic; all decisions use pre-tick values
    always_comb begin
        w_state_nxt = r_state;
        w_px_nxt    = r_px;
        w_py_nxt    = r_py;
        w_rise_nxt  = r_rise;
        w_off_nxt   = r_off;
        w_score_nxt = r_score;
`ifdef JUMP_GAME_BLINK_EN
        w_blink_nxt = r_blink;
`endif
        case (r_state)
            S_IDLE, S_OVER: begin
                if (start) begin
                    w_state_nxt = S_PLAY;
                    w_px_nxt    = X_INIT;
                    w_py_nxt    = '0;
                    w_rise_nxt  = RISE_INIT;
                    w_off_nxt   = '0;
                    w_score_nxt = '0;
`ifdef JUMP_GAME_BLINK_EN
                    w_blink_nxt = '0;
                end else if (r_state == S_OVER && tick) begin
                    w_blink_nxt = r_blink + 2'd1;
`endif
                end
            end
            S_PLAY: begin
                if (tick) begin
                    // N is a power of two, so plain add/subtract wraps the column
                    if (key_left && !key_right) begin
                        w_px_nxt = r_px - XW'(1);
                    end else if (key_right && !key_left) begin
                        w_px_nxt = r_px + XW'(1);
                    end

                    if (r_rise != '0) begin
                        w_rise_nxt = r_rise - RW'(1);
                        if (r_py < SCROLL_Y) begin
                            w_py_nxt = r_py + XW'(1);
                        end else begin
                            w_off_nxt = r_off + MAP_AW'(1);
                            if (r_score != '1) begin
                                w_score_nxt = r_score + SCORE_W'(1);
                            end
                        end
                    end else if (probe_data[r_px]) begin
                        w_rise_nxt = RISE_INIT;
                    end else if (r_py == '0) begin
                        w_state_nxt = S_OVER;
                        w_px_nxt    = r_px;
`ifdef JUMP_GAME_BLINK_EN
                        w_blink_nxt = '0;
`endif
                    end else begin
                        w_py_nxt = r_py - XW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_onehot = N'(1) << r_px;

    // Player pixel overlay for the row currently being scanned
    always_comb begin
        red_row = '0;
        if (r_state != S_IDLE && scan_idx == r_py) begin
`ifdef JUMP_GAME_BLINK_EN
            red_row = (r_state == S_OVER) ? '1 : w_onehot;
            if (r_blink[1]) begin
                red_row = '0;
            end
`else
            red_row = w_onehot;
`endif
        end
    end

    assign disp_addr  = r_off + MAP_AW'(scan_idx);
    assign probe_addr = r_off + MAP_AW'(r_py);
    assign green_row  = disp_data;

    assign state      = r_state;
    assign score      = r_score;
    assign map_offset = r_off;
    assign player_x   = r_px;
    assign player_y   = r_py;

endmodule

// File: tb/tb_jump_game_ctrl.sv
// Scoreboard bench for jump_game_ctrl: default instance plus a JUMP_H=6 instance for scroll checks.
module tb_jump_game_ctrl;

    localparam int K_STATE = 0;
    localparam int K_SCORE = 1;
    localparam int K_OFF   = 2;
    localparam int K_PX    = 3;
    localparam int K_PY    = 4;
    localparam int K_RED   = 5;
    localparam int K_DADDR = 6;
    localparam int K_PADDR = 7;
    localparam int K_GREEN = 8;

    typedef struct {
        string       name;
        int          dut;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_pass   = 0;

    logic clk = 1'b0;
    logic rst, tick, start, key_left, key_right;
    logic [2:0] scan_idx;

    logic [7:0] map_a [64];
    logic [7:0] map_b [64];

    logic [5:0] disp_addr_a, probe_addr_a, off_a, disp_addr_b, probe_addr_b, off_b;
    logic [7:0] disp_data_a, probe_data_a, green_a, red_a, score_a;
    logic [7:0] disp_data_b, probe_data_b, green_b, red_b, score_b;
    logic [1:0] state_a, state_b;
    logic [2:0] px_a, py_a, px_b, py_b;

    assign disp_data_a  = map_a[disp_addr_a];
    assign probe_data_a = map_a[probe_addr_a];
    assign disp_data_b  = map_b[disp_addr_b];
    assign probe_data_b = map_b[probe_addr_b];

    always #5 clk = ~clk;

    jump_game_ctrl u_a (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .key_left(key_left), .key_right(key_right), .scan_idx(scan_idx),
        .disp_addr(disp_addr_a), .disp_data(disp_data_a),
        .probe_addr(probe_addr_a), .probe_data(probe_data_a),
        .green_row(green_a), .red_row(red_a), .state(state_a), .score(score_a),
        .map_offset(off_a), .player_x(px_a), .player_y(py_a)
    );

    jump_game_ctrl #(.JUMP_H(6), .SCROLL_ROW(4)) u_b (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .key_left(key_left), .key_right(key_right), .scan_idx(scan_idx),
        .disp_addr(disp_addr_b), .disp_data(disp_data_b),
        .probe_addr(probe_addr_b), .probe_data(probe_data_b),
        .green_row(green_b), .red_row(red_b), .state(state_b), .score(score_b),
        .map_offset(off_b), .player_x(px_b), .player_y(py_b)
    );

    function automatic logic [31:0] get_act(input int dut, input int kind);
        logic [31:0] v;
        v = '0;
        case (kind)
            K_STATE: v = (dut == 0) ? 32'(state_a)      : 32'(state_b);
            K_SCORE: v = (dut == 0) ? 32'(score_a)      : 32'(score_b);
            K_OFF:   v = (dut == 0) ? 32'(off_a)        : 32'(off_b);
            K_PX:    v = (dut == 0) ? 32'(px_a)         : 32'(px_b);
            K_PY:    v = (dut == 0) ? 32'(py_a)         : 32'(py_b);
            K_RED:   v = (dut == 0) ? 32'(red_a)        : 32'(red_b);
            K_DADDR: v = (dut == 0) ? 32'(disp_addr_a)  : 32'(disp_addr_b);
            K_PADDR: v = (dut == 0) ? 32'(probe_addr_a) : 32'(probe_addr_b);
            K_GREEN: v = (dut == 0) ? 32'(green_a)      : 32'(green_b);
            default: v = 32'hDEAD_BEEF;
        endcase
        return v;
    endfunction

    // Monitor: compares every queued expectation against the outputs on the falling edge
    initial begin
        exp_t e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e   = q.pop_front();
                act = get_act(e.dut, e.kind);
                n_checks++;
                if (act === e.exp) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        @(negedge clk);
        #1;
    endtask

    task automatic expect_v(input int dut, input int kind, input logic [31:0] v, input string nm);
        exp_t e;
        e.name = nm;
        e.dut  = dut;
        e.kind = kind;
        e.exp  = v;
        q.push_back(e);
    endtask

    task automatic do_tick(input logic l, input logic r);
        tick = 1'b1; key_left = l; key_right = r;
        step();
        tick = 1'b0; key_left = 1'b0; key_right = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int py_seq [8];
        logic [7:0] exp_red;
        rst = 1'b1; tick = 1'b0; start = 1'b0; key_left = 1'b0; key_right = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < 64; i++) begin
            map_a[i] = 8'h00;
            map_b[i] = 8'h00;
        end
        map_a[0] = 8'hFF;
        map_b[0] = 8'hFF;
        step();
        step();
        rst = 1'b0;

        // 1: reset state and row scan
        expect_v(0, K_STATE, 0, "reset_state");
        expect_v(0, K_SCORE, 0, "reset_score");
        expect_v(0, K_OFF,   0, "reset_offset");
        expect_v(0, K_PX,    4, "reset_px");
        expect_v(0, K_PY,    0, "reset_py");
        flush();
        for (int i = 0; i < 8; i++) begin
            scan_idx = 3'(i);
            expect_v(0, K_RED,   0, "idle_red_row");
            expect_v(0, K_DADDR, 32'(i), "idle_disp_addr");
            flush();
        end

        // 2: rise, fall and bounce on row 0
        do_start();
        expect_v(0, K_STATE, 1, "start_state");
        scan_idx = 3'd0;
        expect_v(0, K_GREEN, 32'hFF, "green_passthru");
        expect_v(0, K_RED,   32'h10, "red_start");
        flush();
        n_checks++;
        if (state_a === 2'd1) begin
            n_pass++;
        end else begin
            $display("FAIL direct_start_state: got %0h expected 1", state_a);
        end
        py_seq = '{1, 2, 3, 2, 1, 0, 0, 1};
        for (int i = 0; i < 8; i++) begin
            do_tick(1'b0, 1'b0);
            scan_idx = 3'(py_seq[i]);
            expect_v(0, K_PY,    32'(py_seq[i]), "bounce_py");
            expect_v(0, K_STATE, 1, "bounce_state");
            expect_v(0, K_RED,   32'h10, "bounce_red");
            flush();
        end

        // 3: horizontal moves and wrap
        for (int i = 0; i < 4; i++) begin
            do_tick(1'b1, 1'b0);
            expect_v(0, K_PX, 32'(3 - i), "left_px");
            flush();
        end
        do_tick(1'b1, 1'b0);
        expect_v(0, K_PX, 7, "left_wrap_px");
        expect_v(0, K_PY, 0, "left_wrap_py");
        flush();
        do_tick(1'b1, 1'b1);
        expect_v(0, K_PX,    7, "both_keys_px");
        expect_v(0, K_STATE, 1, "both_keys_state");
        flush();
        do_tick(1'b0, 1'b1);
        expect_v(0, K_PX, 0, "right_wrap_px");
        expect_v(0, K_PY, 1, "right_wrap_py");
        flush();

        // 4: scrolling on the JUMP_H=6 instance
        do_reset();
        do_start();
        for (int i = 1; i <= 4; i++) begin
            do_tick(1'b0, 1'b0);
            expect_v(1, K_PY, 32'(i), "climb_py");
            flush();
        end
        for (int i = 1; i <= 2; i++) begin
            do_tick(1'b0, 1'b0);
            expect_v(1, K_OFF,   32'(i), "scroll_offset");
            expect_v(1, K_SCORE, 32'(i), "scroll_score");
            expect_v(1, K_PY,    4, "scroll_py");
            flush();
        end
        expect_v(1, K_PADDR, 6, "scroll_probe_addr");
        flush();
        n_checks++;
        if (probe_addr_b === 6'd6) begin
            n_pass++;
        end else begin
            $display("FAIL direct_probe_addr: got %0h expected 6", probe_addr_b);
        end

        // 5: fall off the map into OVER, then restart
        map_a[0] = 8'h00;
        do_reset();
        do_start();
        py_seq = '{1, 2, 3, 2, 1, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            do_tick(1'b0, 1'b0);
            expect_v(0, K_PY,    32'(py_seq[i]), "fall_py");
            expect_v(0, K_STATE, 1, "fall_state");
            flush();
        end
        do_tick(1'b0, 1'b0);
        expect_v(0, K_STATE, 2, "over_state");
        expect_v(0, K_PY,    0, "over_py");
        flush();
        n_checks++;
        if (state_a === 2'd2) begin
            n_pass++;
        end else begin
            $display("FAIL direct_over_state: got %0h expected 2", state_a);
        end
        scan_idx = 3'd0;
        for (int k = 0; k < 4; k++) begin
`ifdef JUMP_GAME_BLINK_EN
            exp_red = (k < 2) ? 8'hFF : 8'h00;
`else
            exp_red = 8'h10;
`endif
            expect_v(0, K_RED,   32'(exp_red), "over_red_row");
            expect_v(0, K_STATE, 2, "over_hold_state");
            expect_v(0, K_PX,    4, "over_hold_px");
            flush();
            do_tick(1'b0, 1'b0);
        end
        do_start();
        expect_v(0, K_STATE, 1, "restart_state");
        expect_v(0, K_SCORE, 0, "restart_score");
        expect_v(0, K_OFF,   0, "restart_offset");
        expect_v(0, K_PX,    4, "restart_px");
        expect_v(0, K_PY,    0, "restart_py");
        flush();

        // 6: start ignored in PLAY, reset overrides mid-rise
        do_tick(1'b0, 1'b0);
        do_start();
        expect_v(0, K_STATE, 1, "play_start_state");
        expect_v(0, K_PY,    1, "play_start_py");
        flush();
        do_tick(1'b0, 1'b0);
        expect_v(0, K_PY, 2, "midrise_py");
        flush();
        rst = 1'b1; tick = 1'b1; start = 1'b1;
        step();
        rst = 1'b0; tick = 1'b0; start = 1'b0;
        expect_v(0, K_STATE, 0, "rst_mid_state");
        expect_v(0, K_PY,    0, "rst_mid_py");
        flush();
        do_tick(1'b0, 1'b0);
        expect_v(0, K_STATE, 0, "idle_tick_state");
        flush();
        tick = 1'b1; start = 1'b1;
        step();
        tick = 1'b0; start = 1'b0;
        expect_v(0, K_STATE, 1, "start_tick_state");
        expect_v(0, K_PY,    0, "start_tick_py");
        flush();
        n_checks++;
        if (state_a === 2'd1 && py_a === 3'd0) begin
            n_pass++;
        end else begin
            $display("FAIL direct_start_tick: got %0h/%0h expected 1/0", state_a, py_a);
        end

        flush();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
